// File: rtl/stepper_pkg.sv
// stepper_pkg: shared FSM/request types, coil tables and phase width for the stepper sequencer.
// Defining STEPPER_HALF_STEP_EN selects the 8-entry half-step table and a 3-bit phase.
package stepper_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;
    typedef enum logic [1:0] {REQ_STOP, REQ_CW, REQ_CCW} req_t;
    // Entry 0 is the rightmost element.
    localparam logic [3:0][3:0] FULL_STEP_TBL = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
    localparam logic [7:0][3:0] HALF_STEP_TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                                 4'b0110, 4'b0100, 4'b1100, 4'b1000};
`ifdef STEPPER_HALF_STEP_EN
    localparam int PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PHASE_RST = 3'd1;
`else
    localparam int PHASE_W = 2;
    localparam logic [PHASE_W-1:0] PHASE_RST = 2'd0;
`endif

    function automatic logic [3:0] coil_pattern(input logic [PHASE_W-1:0] phase);
`ifdef STEPPER_HALF_STEP_EN
        return HALF_STEP_TBL[phase];
`else
        return FULL_STEP_TBL[phase];
`endif
    endfunction

    function automatic req_t decode_req(input logic [1:0] rl);
        return rl == 2'b10 ? REQ_CW : rl == 2'b01 ? REQ_CCW : REQ_STOP;
    endfunction
endpackage

// File: rtl/step_rate_divider.sv
// step_rate_divider: step-period counter; tick on the last cycle of each STEP_DIV-cycle period.
module step_rate_divider #(
    parameter int STEP_DIV = 500000
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int CNT_W = $clog2(STEP_DIV);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign tick = run && cnt_q == CNT_W'(STEP_DIV - 1);
    assign cnt_d = (clear || !run || tick) ? '0 : cnt_q + CNT_W'(1);
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/stepper_phase_sequencer.sv
// stepper_phase_sequencer: turns a held direction request into timed coil phases and a signed position.
// Build option STEPPER_HALF_STEP_EN switches to half-stepping (8 phases, position in half-steps).
module stepper_phase_sequencer
    import stepper_pkg::*;
#(
    parameter int STEP_DIV = 500000,
    parameter int POS_W    = 16
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [1:0]              rightLeft,
    input  logic                    enable,
    output logic [3:0]              coils,
    output logic                    moving,
    output logic                    dirCw,
    output logic signed [POS_W-1:0] position
);
    logic [1:0] sync1_q, sync2_q;
    state_t state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic dir_q, dir_d;
    logic [3:0] coils_q, coils_d;
    logic tick, step, rev;
    req_t req;

    assign req = decode_req(sync2_q);
    assign rev = (req == REQ_CW && !dir_q) || (req == REQ_CCW && dir_q);

    // Reversal outranks a coincident tick, and STOP outranks both.
    always_comb begin
        state_d = state_q;
        dir_d = dir_q;
        step = 1'b0;
        if (!enable) state_d = IDLE;
        else begin
            case (state_q)
                IDLE: if (req != REQ_STOP) begin
                    state_d = RUN;
                    dir_d = req == REQ_CW;
                end
                RUN: if (req == REQ_STOP) state_d = IDLE;
                     else if (rev) state_d = DWELL;
                     else step = tick;
                DWELL: if (req == REQ_STOP) state_d = IDLE;
                       else if (tick) begin
                           state_d = RUN;
                           dir_d = req == REQ_CW;
                       end
                default: state_d = IDLE;
            endcase
        end
    end

    assign phase_d = !step ? phase_q : dir_q ? phase_q + PHASE_W'(1) : phase_q - PHASE_W'(1);
    assign pos_d = !step ? pos_q : dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    assign coils_d = enable ? coil_pattern(phase_d) : 4'b0000;

    step_rate_divider #(.STEP_DIV(STEP_DIV)) u_div (
        .clk   (clk),
        .resetN(resetN),
        .clear (state_d != state_q),
        .run   (state_q != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            state_q <= IDLE;
            phase_q <= PHASE_RST;
            pos_q <= '0;
            dir_q <= 1'b1;
            coils_q <= 4'b0000;
        end else begin
            sync1_q <= rightLeft;
            sync2_q <= sync1_q;
            state_q <= state_d;
            phase_q <= phase_d;
            pos_q <= pos_d;
            dir_q <= dir_d;
            coils_q <= coils_d;
        end
    end

    assign coils = coils_q;
    assign moving = state_q == RUN;
    assign dirCw = dir_q;
    assign position = pos_q;
endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// tb_stepper_phase_sequencer: directed and random stimulus against a behavioural stepper model.
module tb_stepper_phase_sequencer;
    localparam int STEP_DIV = 4;
    localparam int POS_W = 16;
`ifdef STEPPER_HALF_STEP_EN
    localparam int NPH = 8;
    localparam int PH0 = 1;
    localparam logic [3:0] TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                       4'b0010, 4'b0011, 4'b0001, 4'b1001};
    localparam logic [3:0] PIN [4] = '{4'b0100, 4'b0110, 4'b0010, 4'b0011};
`else
    localparam int NPH = 4;
    localparam int PH0 = 0;
    localparam logic [3:0] TBL [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    localparam logic [3:0] PIN [4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
`endif

    logic clk = 1'b0;
    logic resetN, enable;
    logic [1:0] rightLeft;
    logic [3:0] coils;
    logic moving, dirCw;
    logic [POS_W-1:0] position;
    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;
    logic hold_cmp = 1'b0;
    logic preload = 1'b0;

    stepper_phase_sequencer #(.STEP_DIV(STEP_DIV), .POS_W(POS_W)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .rightLeft(rightLeft),
        .enable   (enable),
        .coils    (coils),
        .moving   (moving),
        .dirCw    (dirCw),
        .position (position)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 run, 2 dwell; age counts edges since the mode was entered.
    int rl_hist [2];
    int m_mode, m_age, m_phase, m_pos, m_req, nxt;
    bit m_cw, m_tick, m_step, n_cw;
    logic [3:0] m_coils;
    logic [15:0] m_pos16;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rl_hist = '{0, 0};
            m_mode = 0;
            m_age = 0;
            m_phase = PH0;
            m_pos = 0;
            m_cw = 1'b1;
            m_coils = 4'b0000;
        end else begin
            m_req = rl_hist[0] == 2 ? 1 : rl_hist[0] == 1 ? 2 : 0;
            rl_hist = '{rl_hist[1], int'(rightLeft)};
            m_tick = m_mode != 0 && m_age % STEP_DIV == STEP_DIV - 1;
            nxt = m_mode;
            n_cw = m_cw;
            m_step = 1'b0;
            if (!enable) nxt = 0;
            else if (m_mode == 0 && m_req != 0) begin
                nxt = 1;
                n_cw = m_req == 1;
            end else if (m_mode == 1) begin
                if (m_req == 0) nxt = 0;
                else if ((m_req == 1) != m_cw) nxt = 2;
                else m_step = m_tick;
            end else if (m_mode == 2) begin
                if (m_req == 0) nxt = 0;
                else if (m_tick) begin
                    nxt = 1;
                    n_cw = m_req == 1;
                end
            end
            if (m_step) begin
                m_phase = (m_phase + (m_cw ? 1 : NPH - 1)) % NPH;
                m_pos = m_pos + (m_cw ? 1 : -1);
            end
            m_age = nxt == m_mode ? m_age + 1 : 0;
            m_mode = nxt;
            m_cw = n_cw;
            m_coils = enable ? TBL[m_phase] : 4'b0000;
            if (preload) m_pos = 'h7FFE;
        end
        m_pos16 = m_pos[15:0];
    end

    always @(negedge clk) begin
        if (cmp_on && !hold_cmp) begin
            check("coils", {28'b0, coils}, {28'b0, m_coils});
            check("moving", {31'b0, moving}, {31'b0, m_mode == 1});
            check("dirCw", {31'b0, dirCw}, {31'b0, m_cw});
            check("position", {16'b0, position}, {16'b0, m_pos16});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_coils"}, {28'b0, coils}, 32'h0);
        check({tag, "_moving"}, {31'b0, moving}, 32'h0);
        check({tag, "_dirCw"}, {31'b0, dirCw}, 32'h1);
        check({tag, "_position"}, {16'b0, position}, 32'h0);
    endtask

    initial begin
        resetN = 1'b0;
        enable = 1'b0;
        rightLeft = 2'b00;
        cyc(3);
        check_reset_vals("reset");
        cmp_on = 1'b1;
        resetN = 1'b1;
        enable = 1'b1;
        cyc(2);
        rightLeft = 2'b10;
        cyc(6);
        check("pre_step_pos", {16'b0, position}, 32'h0);
        check("pre_step_coils", {28'b0, coils}, 32'hC);
        check("run_moving", {31'b0, moving}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(i == 0 ? 1 : 4);
            check("cw_pos", {16'b0, position}, 32'(i + 1));
            check("cw_coils", {28'b0, coils}, {28'b0, PIN[i]});
        end
        rightLeft = 2'b01;
        cyc(3);
        check("dwell_moving", {31'b0, moving}, 32'h0);
        check("dwell_pos", {16'b0, position}, 32'h4);
        cyc(4);
        check("rev_dir", {31'b0, dirCw}, 32'h0);
        check("rev_moving", {31'b0, moving}, 32'h1);
        cyc(4);
        check("ccw_pos", {16'b0, position}, 32'h3);
        rightLeft = 2'b11;
        cyc(3);
        check("stop11_moving", {31'b0, moving}, 32'h0);
        cyc(10);
        check("stop11_pos", {16'b0, position}, 32'h3);
        rightLeft = 2'b01;
        cyc(7);
        check("ccw2_pos", {16'b0, position}, 32'h2);
        rightLeft = 2'b00;
        cyc(3);
        check("stop00_moving", {31'b0, moving}, 32'h0);
        rightLeft = 2'b10;
        cyc(5);
        enable = 1'b0;
        cyc(1);
        check("dis_coils", {28'b0, coils}, 32'h0);
        check("dis_moving", {31'b0, moving}, 32'h0);
        check("dis_pos", {16'b0, position}, 32'h2);
        enable = 1'b1;
        cyc(1);
        check("reen_moving", {31'b0, moving}, 32'h1);
        cyc(4);
        check("reen_pos", {16'b0, position}, 32'h3);
        rightLeft = 2'b00;
        cyc(4);
        @(posedge clk);
        #1;
        hold_cmp = 1'b1;
        preload = 1'b1;
        force dut.pos_q = 16'sh7FFE;
        @(posedge clk);
        #1;
        release dut.pos_q;
        preload = 1'b0;
        hold_cmp = 1'b0;
        @(negedge clk);
        rightLeft = 2'b10;
        cyc(7);
        check("pos_7fff", {16'b0, position}, 32'h7FFF);
        cyc(4);
        check("pos_wrap", {16'b0, position}, 32'h8000);
        cyc(2);
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) rightLeft = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) enable = $urandom_range(0, 3) != 0;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
